// File: rtl/predecode_recover_sdr_2r1w_64.sv
`default_nettype none
// ============================================================================
// Module   : predecode_recover_sdr_2r1w_64
// Function : Receive-side monitor for the SDR 2r1w 64-word predecoder. It
//            samples the one-hot line groups of two read ports and one write
//            port. It recovers an enable and a 6-bit address per port, flags
//            non-one-hot patterns and optionally detects write/read address
//            collisions. Two-stage pipeline.
// Options  : PREDECODE_RECOVER_COLLISION_EN enables the collision compare,
//            coll_r0/coll_r1 and coll_cnt. When it is not defined, those
//            outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module predecode_recover_sdr_2r1w_64 (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] rd0_pd,
    input  logic [0:11] rd1_pd,
    input  logic [0:11] wr0_pd,
    input  logic        err_clr,
    output logic        rd0_enb,
    output logic        rd1_enb,
    output logic        wr0_enb,
    output logic [0:5]  rd0_adr,
    output logic [0:5]  rd1_adr,
    output logic [0:5]  wr0_adr,
    output logic        rd0_err,
    output logic        rd1_err,
    output logic        wr0_err,
    output logic        err_sticky,
    output logic [7:0]  err_cnt,
    output logic        coll_r0,
    output logic        coll_r1,
    output logic [7:0]  coll_cnt
);

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    // Legal pattern: every group carries exactly one active line.
    function automatic logic pd_valid(input logic [0:11] pd);
        return $onehot(pd[0:1]) && $onehot(pd[2:5]) &&
               $onehot(pd[6:7]) && $onehot(pd[8:11]);
    endfunction

    // Any non-idle pattern that is not legal is an error.
    function automatic logic pd_error(input logic [0:11] pd);
        return (pd != 12'b0) && !pd_valid(pd);
    endfunction

    // Re-encode one-hot groups into address bits; only meaningful when legal.
    function automatic logic [0:5] pd_encode(input logic [0:11] pd);
        logic [0:5] adr;
        adr[0] = pd[1];
        adr[1] = pd[4]  | pd[5];
        adr[2] = pd[3]  | pd[5];
        adr[3] = pd[7];
        adr[4] = pd[10] | pd[11];
        adr[5] = pd[9]  | pd[11];
        return adr;
    endfunction

    logic [0:11] r_rd0_pd;
    logic [0:11] r_rd1_pd;
    logic [0:11] r_wr0_pd;

    logic        w_rd0_vld, w_rd1_vld, w_wr0_vld;
    logic        w_rd0_err, w_rd1_err, w_wr0_err;
    logic [0:5]  w_rd0_adr, w_rd1_adr, w_wr0_adr;
    logic        w_any_err;
    logic [7:0]  w_err_cnt_nxt;

    logic        r_rd0_enb, r_rd1_enb, r_wr0_enb;
    logic [0:5]  r_rd0_adr, r_rd1_adr, r_wr0_adr;
    logic        r_rd0_err, r_rd1_err, r_wr0_err;
    logic        r_err_sticky;
    logic [7:0]  r_err_cnt;

    // Stage 1: unconditional capture of all predecode lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd0_pd <= '0;
            r_rd1_pd <= '0;
            r_wr0_pd <= '0;
        end else begin
            r_rd0_pd <= rd0_pd;
            r_rd1_pd <= rd1_pd;
            r_wr0_pd <= wr0_pd;
        end
    end

    assign w_rd0_vld = pd_valid(r_rd0_pd);
    assign w_rd1_vld = pd_valid(r_rd1_pd);
    assign w_wr0_vld = pd_valid(r_wr0_pd);
    assign w_rd0_err = pd_error(r_rd0_pd);
    assign w_rd1_err = pd_error(r_rd1_pd);
    assign w_wr0_err = pd_error(r_wr0_pd);
    assign w_rd0_adr = w_rd0_vld ? pd_encode(r_rd0_pd) : 6'b0;
    assign w_rd1_adr = w_rd1_vld ? pd_encode(r_rd1_pd) : 6'b0;
    assign w_wr0_adr = w_wr0_vld ? pd_encode(r_wr0_pd) : 6'b0;
    assign w_any_err = w_rd0_err | w_rd1_err | w_wr0_err;

    // Error counter next value: clear first, then count this cycle's event.
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (err_clr) begin
            w_err_cnt_nxt = w_any_err ? 8'd1 : 8'd0;
        end else if (w_any_err && (r_err_cnt != c_CNT_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end
    end

    // Stage 2: registered port results, sticky flag and error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd0_enb    <= 1'b0;
            r_rd1_enb    <= 1'b0;
            r_wr0_enb    <= 1'b0;
            r_rd0_adr    <= '0;
            r_rd1_adr    <= '0;
            r_wr0_adr    <= '0;
            r_rd0_err    <= 1'b0;
            r_rd1_err    <= 1'b0;
            r_wr0_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_rd0_enb    <= w_rd0_vld;
            r_rd1_enb    <= w_rd1_vld;
            r_wr0_enb    <= w_wr0_vld;
            r_rd0_adr    <= w_rd0_adr;
            r_rd1_adr    <= w_rd1_adr;
            r_wr0_adr    <= w_wr0_adr;
            r_rd0_err    <= w_rd0_err;
            r_rd1_err    <= w_rd1_err;
            r_wr0_err    <= w_wr0_err;
            r_err_sticky <= err_clr ? w_any_err : (r_err_sticky | w_any_err);
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign rd0_enb    = r_rd0_enb;
    assign rd1_enb    = r_rd1_enb;
    assign wr0_enb    = r_wr0_enb;
    assign rd0_adr    = r_rd0_adr;
    assign rd1_adr    = r_rd1_adr;
    assign wr0_adr    = r_wr0_adr;
    assign rd0_err    = r_rd0_err;
    assign rd1_err    = r_rd1_err;
    assign wr0_err    = r_wr0_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

`ifdef PREDECODE_RECOVER_COLLISION_EN
    logic       w_coll_r0, w_coll_r1, w_any_coll;
    logic [7:0] w_coll_cnt_nxt;
    logic       r_coll_r0, r_coll_r1;
    logic [7:0] r_coll_cnt;

    // Encoded addresses are forced to 0 when not valid, so validity gates too.
    assign w_coll_r0  = w_wr0_vld & w_rd0_vld & (w_wr0_adr == w_rd0_adr);
    assign w_coll_r1  = w_wr0_vld & w_rd1_vld & (w_wr0_adr == w_rd1_adr);
    assign w_any_coll = w_coll_r0 | w_coll_r1;

    // Collision counter next value: clear first, then count this cycle's event.
    always_comb begin
        w_coll_cnt_nxt = r_coll_cnt;
        if (err_clr) begin
            w_coll_cnt_nxt = w_any_coll ? 8'd1 : 8'd0;
        end else if (w_any_coll && (r_coll_cnt != c_CNT_MAX)) begin
            w_coll_cnt_nxt = r_coll_cnt + 8'd1;
        end
    end

    // Stage 2 collision flags and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_coll_r0  <= 1'b0;
            r_coll_r1  <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll_r0  <= w_coll_r0;
            r_coll_r1  <= w_coll_r1;
            r_coll_cnt <= w_coll_cnt_nxt;
        end
    end

    assign coll_r0  = r_coll_r0;
    assign coll_r1  = r_coll_r1;
    assign coll_cnt = r_coll_cnt;
`else
    assign coll_r0  = 1'b0;
    assign coll_r1  = 1'b0;
    assign coll_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_predecode_recover_sdr_2r1w_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_predecode_recover_sdr_2r1w_64
// Function : Self-checking bench for predecode_recover_sdr_2r1w_64. The
//            expected port results are queued when the stimulus is driven and
//            compared two edges later. Counters and the sticky flag are
//            tracked by a small reference model. Honours
//            PREDECODE_RECOVER_COLLISION_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_predecode_recover_sdr_2r1w_64;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:11] rd0_pd, rd1_pd, wr0_pd;
    logic        err_clr;
    logic        rd0_enb, rd1_enb, wr0_enb;
    logic [0:5]  rd0_adr, rd1_adr, wr0_adr;
    logic        rd0_err, rd1_err, wr0_err;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic        coll_r0, coll_r1;
    logic [7:0]  coll_cnt;

    always #5 clk = ~clk;

    predecode_recover_sdr_2r1w_64 dut (
        .clk        (clk),
        .reset      (reset),
        .rd0_pd     (rd0_pd),
        .rd1_pd     (rd1_pd),
        .wr0_pd     (wr0_pd),
        .err_clr    (err_clr),
        .rd0_enb    (rd0_enb),
        .rd1_enb    (rd1_enb),
        .wr0_enb    (wr0_enb),
        .rd0_adr    (rd0_adr),
        .rd1_adr    (rd1_adr),
        .wr0_adr    (wr0_adr),
        .rd0_err    (rd0_err),
        .rd1_err    (rd1_err),
        .wr0_err    (wr0_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .coll_r0    (coll_r0),
        .coll_r1    (coll_r1),
        .coll_cnt   (coll_cnt)
    );

    // Port kinds used by the stimulus
    localparam int K_IDLE = 0;
    localparam int K_LEGAL = 1;
    localparam int K_ILL = 2;

    typedef struct {
        logic       en0, en1, enw;
        logic       er0, er1, erw;
        logic [0:5] a0, a1, aw;
        logic       c0, c1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   stepn = 0;
    int   m_err = 0;
    int   m_coll = 0;
    logic m_sticky = 1'b0;

    // Build the legal one-hot pattern for address v (adr[0] is the MSB).
    function automatic logic [0:11] legal_pd(input int v);
        logic [0:5]  a;
        logic [0:11] pd;
        int          i1, i3;
        a  = 6'(v);
        pd = '0;
        pd[a[0] ? 1 : 0] = 1'b1;
        i1 = {30'd0, a[1], a[2]};
        pd[2 + i1] = 1'b1;
        pd[a[3] ? 7 : 6] = 1'b1;
        i3 = {30'd0, a[4], a[5]};
        pd[8 + i3] = 1'b1;
        return pd;
    endfunction

    function automatic logic [0:11] pd_of(input int k, input int v);
        if (k == K_LEGAL) return legal_pd(v);
        if (k == K_ILL)   return 12'(v);
        return 12'b0;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.en0 = 0; e.en1 = 0; e.enw = 0;
        e.er0 = 0; e.er1 = 0; e.erw = 0;
        e.a0 = '0; e.a1 = '0; e.aw = '0;
        e.c0 = 0; e.c1 = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s@%0d observed=%0h expected=%0h", tag, stepn, obs, exp);
        end
    endtask

    task automatic check_all_zero();
        chk("rst_enb", {29'd0, rd0_enb, rd1_enb, wr0_enb}, 32'd0);
        chk("rst_adr", {14'd0, rd0_adr, rd1_adr, wr0_adr}, 32'd0);
        chk("rst_err", {29'd0, rd0_err, rd1_err, wr0_err}, 32'd0);
        chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_coll", {30'd0, coll_r0, coll_r1}, 32'd0);
        chk("rst_coll_cnt", {24'd0, coll_cnt}, 32'd0);
    endtask

    // Drive one sample, advance one edge and compare the result due now.
    task automatic step(input int k0, input int v0, input int k1, input int v1,
                        input int kw, input int vw, input logic clr);
        exp_t e;
        logic any_err, any_coll;
        rd0_pd  = pd_of(k0, v0);
        rd1_pd  = pd_of(k1, v1);
        wr0_pd  = pd_of(kw, vw);
        err_clr = clr;
        e = idle_exp();
        e.en0 = (k0 == K_LEGAL); e.en1 = (k1 == K_LEGAL); e.enw = (kw == K_LEGAL);
        e.er0 = (k0 == K_ILL);   e.er1 = (k1 == K_ILL);   e.erw = (kw == K_ILL);
        e.a0  = e.en0 ? 6'(v0) : 6'd0;
        e.a1  = e.en1 ? 6'(v1) : 6'd0;
        e.aw  = e.enw ? 6'(vw) : 6'd0;
`ifdef PREDECODE_RECOVER_COLLISION_EN
        e.c0  = e.enw && e.en0 && (vw == v0);
        e.c1  = e.enw && e.en1 && (vw == v1);
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
        stepn++;
        if (q.size() >= 2) e = q.pop_front();
        else               e = idle_exp();
        any_err  = e.er0 | e.er1 | e.erw;
        any_coll = e.c0 | e.c1;
        if (clr) begin
            m_err    = any_err ? 1 : 0;
            m_coll   = any_coll ? 1 : 0;
            m_sticky = any_err;
        end else begin
            if (any_err && m_err < 255) m_err++;
            if (any_coll && m_coll < 255) m_coll++;
            m_sticky = m_sticky | any_err;
        end
        chk("rd0_enb", {31'd0, rd0_enb}, {31'd0, e.en0});
        chk("rd1_enb", {31'd0, rd1_enb}, {31'd0, e.en1});
        chk("wr0_enb", {31'd0, wr0_enb}, {31'd0, e.enw});
        chk("rd0_adr", {26'd0, rd0_adr}, {26'd0, e.a0});
        chk("rd1_adr", {26'd0, rd1_adr}, {26'd0, e.a1});
        chk("wr0_adr", {26'd0, wr0_adr}, {26'd0, e.aw});
        chk("rd0_err", {31'd0, rd0_err}, {31'd0, e.er0});
        chk("rd1_err", {31'd0, rd1_err}, {31'd0, e.er1});
        chk("wr0_err", {31'd0, wr0_err}, {31'd0, e.erw});
        chk("coll_r0", {31'd0, coll_r0}, {31'd0, e.c0});
        chk("coll_r1", {31'd0, coll_r1}, {31'd0, e.c1});
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
        chk("err_cnt", {24'd0, err_cnt}, 32'(m_err));
        chk("coll_cnt", {24'd0, coll_cnt}, 32'(m_coll));
    endtask

    initial begin
        reset   = 1'b1;
        rd0_pd  = '0;
        rd1_pd  = '0;
        wr0_pd  = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        @(negedge clk);
        reset = 1'b0;

        // Address sweep on all ports
        for (int v = 0; v < 64; v++)
            step(K_LEGAL, v, K_LEGAL, 63 - v, K_LEGAL, (v * 5 + 3) % 64, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);

        // Illegal: rd0 G1=0011, then all three ports illegal in one cycle
        step(K_ILL, 12'b10_0011_10_1000, K_LEGAL, 9, K_LEGAL, 20, 1'b0);
        step(K_ILL, 12'b01_0000_01_0001, K_ILL, 12'b11_1000_10_1000,
             K_ILL, 12'b00_0000_00_0001, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);

        // Collision: write and read 1 at 37, read 0 elsewhere
        step(K_LEGAL, 36, K_LEGAL, 37, K_LEGAL, 37, 1'b0);
        step(K_LEGAL, 0, K_LEGAL, 63, K_LEGAL, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);

        // Saturation: 300 error cycles
        for (int i = 0; i < 300; i++)
            step(K_ILL, 12'hFFF, K_IDLE, 0, K_IDLE, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);

        // Clear with no event, then clear coinciding with an error
        step(K_ILL, 12'h800, K_IDLE, 0, K_IDLE, 0, 1'b1);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b1);
        chk("err_cnt_clr_hit", {24'd0, err_cnt}, 32'd1);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b1);
        chk("err_cnt_clr", {24'd0, err_cnt}, 32'd0);
        step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);

        // Reset mid-stream
        for (int v = 0; v < 5; v++)
            step(K_LEGAL, v, K_LEGAL, v + 10, K_LEGAL, v, 1'b0);
        reset = 1'b1;
        #1;
        check_all_zero();
        q.delete();
        m_err    = 0;
        m_coll   = 0;
        m_sticky = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int v = 40; v < 46; v++)
            step(K_LEGAL, v, K_LEGAL, 63 - v, K_LEGAL, v, 1'b0);

        // Idle drain
        for (int i = 0; i < 3; i++)
            step(K_IDLE, 0, K_IDLE, 0, K_IDLE, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/predecode_recover_sdr_2r1w_64.md
# predecode_recover_sdr_2r1w_64

Receive-side companion to the SDR 2r1w 64-word predecoder. It samples the three ports' one-hot predecoded line groups and re-encodes each into an enable plus a 6-bit address. It also flags illegal (non-one-hot) group patterns and detects same-cycle write/read address collisions. It sits beside the array shard as a self-check monitor and as a bench/FPGA observability point; it never drives the array.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd0_pd  in  [0:11]  read port 0 predecode lines, packed as listed below
- rd1_pd  in  [0:11]  read port 1 predecode lines
- wr0_pd  in  [0:11]  write port 0 predecode lines
- err_clr  in  1  synchronous clear of sticky error and both counters
- rd0_enb, rd1_enb, wr0_enb  out  1  recovered enable per port
- rd0_adr, rd1_adr, wr0_adr  out  [0:5]  recovered address per port
- rd0_err, rd1_err, wr0_err  out  1  illegal pattern on port in this sample
- err_sticky  out  1  any port error since last clear
- err_cnt  out  [7:0]  saturating count of error cycles
- coll_r0, coll_r1  out  1  write address equals read 0 / read 1 address
- coll_cnt  out  [7:0]  saturating count of collision cycles

Packing of each pd bus:
- [0] c_na0, [1] c_a0
- [2] na1_na2, [3] na1_a2, [4] a1_na2, [5] a1_a2
- [6] na3, [7] a3
- [8] na4_na5, [9] na4_a5, [10] a4_na5, [11] a4_a5

## Operation
- Stage 1: register all 36 pd lines every cycle; no enable.
- Stage 2: per port, from the stage-1 copy:
  - Groups: G0=[0:1], G1=[2:5], G2=[6:7], G3=[8:11].
  - idle: all 12 bits 0.
  - valid: each group has exactly one bit set.
  - error: neither idle nor valid. This includes partial groups, multi-hot groups, and some groups active while others are zero.
- Encoding when valid:
  - adr[0]=pd[1]
  - adr[1:2] = index of the set bit in G1 (00..11 for bits 2..5)
  - adr[3]=pd[7]
  - adr[4:5] = index of the set bit in G3 (bits 8..11)
- Port outputs: enb=valid; adr=encoded value if valid, else 6'b0; err=error.
- Collision: coll_rN=1 when wr0 valid, rdN valid, and the two encoded addresses are equal.
- Counters, updated at the stage-2 edge:
  - err_cnt increments by 1 per cycle in which any port errors, regardless of how many ports err.
  - coll_cnt increments by 1 per cycle in which coll_r0 or coll_r1 is set.
  - Both saturate at 8'hFF; there is no wrap.
- err_sticky sets on any port error and holds until err_clr.
- err_clr together with a new event in the same cycle: clear takes effect first, then the event applies. Result: sticky=1 and the counter reads 1.

## Timing
- Inputs must be stable across the rising clk edge. When the monitor is in use, predecoder strobe is held high.
- Latency: lines present at edge N appear on enb/adr/err/coll after edge N+1, i.e. 2 edges from input to output.
- err_sticky, err_cnt and coll_cnt reflect the sample taken at edge N after edge N+1.
- err_clr sampled at edge M zeroes counters and sticky after edge M.
- Reset value of every output and internal register is 0.
- Reset asserted mid-stream flushes both stages immediately. The first valid output appears 2 edges after reset deassertion.
- Fully pipelined: one new sample per cycle; no backpressure and no handshake.

## Configuration
- PREDECODE_RECOVER_COLLISION_EN defined:
  - collision compare, coll_r0/coll_r1 and coll_cnt are implemented as described.
- Not defined:
  - compare logic and counter are omitted.
  - coll_r0, coll_r1 and coll_cnt are tied to 0.
  - all other behaviour is unchanged.

## Test plan
- Address sweep: drive legal patterns for addresses 0..63 on all ports, one per cycle -> each adr matches, enb=1, err=0, 2-cycle latency.
- Illegal patterns: rd0_pd with G1=0011 -> rd0_err=1, rd0_enb=0, rd0_adr=0, err_sticky=1, err_cnt=1. Same cycle with rd1 and wr0 also illegal -> err_cnt still increments by 1.
- Collision (macro on): wr0 and rd1 both at address 6'd37 -> coll_r1=1, coll_r0=0, coll_cnt=1. Macro off -> all collision outputs 0.
- Saturation and clear: 300 consecutive error cycles -> err_cnt=8'hFF. err_clr with no error -> 0. err_clr coinciding with an error -> err_cnt=1.
- Reset mid-stream: assert reset during the sweep -> all outputs 0 at once. After release, the first valid address appears at the 2nd edge.
- Idle: all pd lines 0 -> enb=0, err=0, counters unchanged.
